// File: rtl/reg_req_adapter.sv
// Request/response bus to register-file strobe adapter with a two-state handshake FSM.
// Optional error counter output err_cnt_o enabled by defining REG_REQ_ADAPTER_ERR_CNT_EN.
module reg_req_adapter #(
  parameter int NumRegs = 4,
  parameter int AW      = 8,
  parameter int DW      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wdata_i,
  input  logic [DW/8-1:0]       be_i,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  output logic [DW-1:0]         rdata_o,
  output logic                  err_o,
  output logic [NumRegs-1:0]    reg_we_o,
  output logic [NumRegs-1:0]    reg_re_o,
  output logic [DW-1:0]         reg_wd_o,
  input  logic [NumRegs*DW-1:0] reg_qs_i
`ifdef REG_REQ_ADAPTER_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt_o
`endif
);

  typedef enum logic {Idle, Resp} state_e;

  state_e               state_q;
  logic                 rvalid_q;
  logic [DW-1:0]        rdata_q;
  logic                 err_q;

  logic [AW-3:0]        idx;
  logic [NumRegs-1:0]   hit;
  logic [DW-1:0]        qs_sel;
  logic                 req_err;
  logic                 accept;
  logic                 wr_ok;
  logic                 rd_ok;

  assign idx = addr_i[AW-1:2];

  // Decode by loop so out-of-range indices simply produce no hit.
  always_comb begin
    hit    = '0;
    qs_sel = '0;
    for (int k = 0; k < NumRegs; k++) begin
      if (32'(idx) == 32'(k)) begin
        hit[k] = 1'b1;
        qs_sel = reg_qs_i[k*DW +: DW];
      end
    end
  end

  assign req_err = (addr_i[1:0] != 2'b00) || (hit == '0) || (we_i && (be_i != '1));
  assign gnt_o   = rst_ni && (state_q == Idle);
  assign accept  = req_i && gnt_o;
  assign wr_ok   = accept && we_i && !req_err;
  assign rd_ok   = accept && !we_i && !req_err;

  assign reg_we_o = wr_ok ? hit : '0;
  assign reg_re_o = rd_ok ? hit : '0;
  assign reg_wd_o = wr_ok ? wdata_i : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        Idle: begin
          if (accept) begin
            state_q  <= Resp;
            rvalid_q <= 1'b1;
            rdata_q  <= rd_ok ? qs_sel : '0;
            err_q    <= req_err;
          end
        end
        Resp: begin
          if (rready_i) begin
            state_q  <= Idle;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
          end
        end
        default: state_q <= Idle;
      endcase
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

`ifdef REG_REQ_ADAPTER_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q <= '0;
    end else if (accept && req_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_reg_req_adapter.sv
// Directed scoreboard bench for reg_req_adapter (NumRegs=4, AW=8).
module tb_reg_req_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic         gnt;
  logic         we;
  logic [7:0]   addr;
  logic [31:0]  wdata;
  logic [3:0]   be;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic         err;
  logic [3:0]   reg_we;
  logic [3:0]   reg_re;
  logic [31:0]  reg_wd;
  logic [127:0] qs;
`ifdef REG_REQ_ADAPTER_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  always #5 clk = ~clk;

  reg_req_adapter #(.NumRegs(4), .AW(8), .DW(32)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .gnt_o    (gnt),
    .we_i     (we),
    .addr_i   (addr),
    .wdata_i  (wdata),
    .be_i     (be),
    .rvalid_o (rvalid),
    .rready_i (rready),
    .rdata_o  (rdata),
    .err_o    (err),
    .reg_we_o (reg_we),
    .reg_re_o (reg_re),
    .reg_wd_o (reg_wd),
    .reg_qs_i (qs)
`ifdef REG_REQ_ADAPTER_ERR_CNT_EN
    ,
    .err_cnt_o(err_cnt)
`endif
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [3:0] exp_we,
                       input logic [3:0] exp_re, input logic [31:0] exp_rd,
                       input logic exp_err);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    #1;
    check("gnt_idle", 64'(gnt), 64'(1));
    check("we_strobe", 64'(reg_we), 64'(exp_we));
    check("re_strobe", 64'(reg_re), 64'(exp_re));
    check("wd", 64'(reg_wd), (exp_we != 4'b0) ? 64'(d) : 64'(0));
    sb.push_back('{rdata: exp_rd, err: exp_err});
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    check("strobe_one_cycle", 64'({reg_we, reg_re, reg_wd}), 64'(0));
  endtask

  task automatic respond(input int stall);
    resp_t e;
    int waited;
    waited = 0;
    while (!rvalid && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("rvalid_up", 64'(rvalid), 64'(1));
    check("sb_has_entry", 64'(sb.size() != 0), 64'(1));
    e = (sb.size() != 0) ? sb.pop_front() : '0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      #1;
      check("stall_rvalid", 64'(rvalid), 64'(1));
      check("stall_rdata", 64'(rdata), 64'(e.rdata));
      check("stall_gnt", 64'(gnt), 64'(0));
      check("stall_strobes", 64'({reg_we, reg_re}), 64'(0));
    end
    @(negedge clk);
    rready = 1'b1;
    #1;
    check("resp_rdata", 64'(rdata), 64'(e.rdata));
    check("resp_err", 64'(err), 64'(e.err));
    check("hs_gnt", 64'(gnt), 64'(0));
    check("hs_strobes", 64'({reg_we, reg_re}), 64'(0));
    @(posedge clk);
    #1;
    rready = 1'b0;
    check("post_rvalid", 64'(rvalid), 64'(0));
    check("post_clear", 64'({rdata, err}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b1; we = 1'b0; addr = '0; wdata = '0; be = '0;
    rready = 1'b0; qs = '0;
    #12;
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_resp", 64'({rvalid, rdata, err}), 64'(0));
    check("rst_strobes", 64'({reg_we, reg_re, reg_wd}), 64'(0));
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0;
    #1;
    check("rel_gnt", 64'(gnt), 64'(1));

    issue(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 4'b0010, 4'b0000, 32'h0, 1'b0);
    respond(0);

    qs[2*32 +: 32] = 32'h12345678;
    issue(1'b0, 8'h08, 32'h0, 4'h0, 4'b0000, 4'b0100, 32'h12345678, 1'b0);
    respond(0);

    issue(1'b0, 8'h10, 32'h0, 4'hF, 4'b0000, 4'b0000, 32'h0, 1'b1);
    respond(0);
    issue(1'b1, 8'h05, 32'hCAFEF00D, 4'hF, 4'b0000, 4'b0000, 32'h0, 1'b1);
    respond(0);
    issue(1'b1, 8'h00, 32'h11112222, 4'h3, 4'b0000, 4'b0000, 32'h0, 1'b1);
    respond(0);
`ifdef REG_REQ_ADAPTER_ERR_CNT_EN
    check("err_cnt_3", 64'(err_cnt), 64'(3));
`endif

    // Stall with a pending request held; source data changes must not leak into rdata.
    qs[1*32 +: 32] = 32'hA5A55A5A;
    qs[3*32 +: 32] = 32'h0BADCAFE;
    issue(1'b0, 8'h04, 32'h0, 4'h0, 4'b0000, 4'b0010, 32'hA5A55A5A, 1'b0);
    qs[1*32 +: 32] = 32'hFFFF0000;
    req = 1'b1; we = 1'b0; addr = 8'h0C;
    respond(5);
    check("after_hs_gnt", 64'(gnt), 64'(1));
    check("after_hs_re", 64'(reg_re), 64'(4'b1000));
    sb.push_back('{rdata: 32'h0BADCAFE, err: 1'b0});
    @(posedge clk);
    #1;
    req = 1'b0; addr = '0;
    respond(0);

    issue(1'b0, 8'h00, 32'h0, 4'h0, 4'b0000, 4'b0001, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0; req = 1'b1; addr = 8'h00;
    #1;
    check("rstresp_rvalid", 64'(rvalid), 64'(0));
    check("rstresp_data", 64'({rdata, err}), 64'(0));
    check("rstresp_gnt", 64'(gnt), 64'(0));
    check("rstresp_strobes", 64'({reg_we, reg_re}), 64'(0));
    if (sb.size() != 0) void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1; req = 1'b0;
    #1;
    check("rstrel_gnt", 64'(gnt), 64'(1));
    check("rstrel_rvalid", 64'(rvalid), 64'(0));
    @(negedge clk);
    #1;
    check("rstrel_idle", 64'({rvalid, reg_we, reg_re}), 64'(0));

`ifdef REG_REQ_ADAPTER_ERR_CNT_EN
    check("err_cnt_rst", 64'(err_cnt), 64'(0));
    for (int i = 0; i < 256; i++) begin
      issue(1'b0, 8'h13, 32'h0, 4'h0, 4'b0000, 4'b0000, 32'h0, 1'b1);
      respond(0);
      if (i == 253) check("err_cnt_254", 64'(err_cnt), 64'(254));
    end
    check("err_cnt_sat", 64'(err_cnt), 64'(255));
`endif

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_req_adapter.md
REG_REQ_ADAPTER -- requirements
Module: reg_req_adapter

Interface
REQ-001 Parameter NumRegs, default 4: number of 32-bit registers served (1..64).
REQ-002 Parameter AW, default 8: byte-address width; register index = addr_i[AW-1:2].
REQ-003 Parameter DW, default 32: data width; only 32 supported.
REQ-004 clk_i  input  1  clock; all state SHALL update on rising edge.
REQ-005 rst_ni  input  1  asynchronous, active-low reset.
REQ-006 req_i  input  1  bus request valid.
REQ-007 gnt_o  output  1  request accepted when req_i && gnt_o.
REQ-008 we_i  input  1  1 = write, 0 = read.
REQ-009 addr_i  input  AW  byte address.
REQ-010 wdata_i  input  DW  write data.
REQ-011 be_i  input  DW/8  byte enables.
REQ-012 rvalid_o  output  1  response valid.
REQ-013 rready_i  input  1  response consumed when rvalid_o && rready_i.
REQ-014 rdata_o  output  DW  read data.
REQ-015 err_o  output  1  response error flag, valid with rvalid_o.
REQ-016 reg_we_o  output  NumRegs  one-hot write strobe to subregister we inputs.
REQ-017 reg_re_o  output  NumRegs  one-hot read strobe (read-clear side effects).
REQ-018 reg_wd_o  output  DW  write data to subregister wd inputs.
REQ-019 reg_qs_i  input  NumRegs*DW  concatenated subregister qs values; register k at [k*DW +: DW].

Function
REQ-020 The FSM SHALL have two states: IDLE and RESP; gnt_o SHALL be 1 in IDLE and 0 in RESP, combinationally.
REQ-021 On acceptance, the FSM SHALL move IDLE->RESP; RESP->IDLE only on rvalid_o && rready_i; no request is granted in the handshake cycle (max one transaction per two cycles).
REQ-022 A request SHALL be erroneous if addr_i[1:0] != 0, if the index >= NumRegs, or if a write has be_i != all-ones.
REQ-023 Valid write: in the acceptance cycle reg_we_o[index] SHALL be 1, with reg_wd_o = wdata_i; all other strobes 0.
REQ-024 Valid read: in the acceptance cycle reg_re_o[index] SHALL be 1, and reg_qs_i of that register SHALL be registered into rdata_o at that edge.
REQ-025 Erroneous request: no strobe SHALL assert; response SHALL be err_o=1, rdata_o=0.
REQ-026 Write responses SHALL carry rdata_o=0, err_o=0.
REQ-027 rvalid_o, rdata_o and err_o SHALL be registered and held stable through RESP until the handshake.
REQ-028 reg_we_o and reg_re_o SHALL be 0 whenever no request is accepted; reg_wd_o SHALL be 0 then too.
REQ-029 rvalid_o SHALL drop in the cycle after the handshake; rdata_o and err_o SHALL then clear to 0.

Reset
REQ-030 On rst_ni low, the FSM SHALL enter IDLE immediately; rvalid_o=0, rdata_o=0, err_o=0.
REQ-031 Reset during RESP SHALL discard the pending response; no strobe SHALL be reissued.
REQ-032 gnt_o SHALL be 0 while rst_ni is low; strobes SHALL be 0.

Configuration
REQ-033 Macro REG_REQ_ADAPTER_ERR_CNT_EN: when defined, the block SHALL add output err_cnt_o (8 bits, reset 0), incremented by 1 on each accepted erroneous request, saturating at 255.
REQ-034 Without REG_REQ_ADAPTER_ERR_CNT_EN, err_cnt_o and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-035 Write addr 0x04, wdata 0xDEADBEEF, be 0xF -> reg_we_o=4'b0010 for one cycle, reg_wd_o=0xDEADBEEF; next cycle rvalid_o=1, err_o=0.
REQ-036 reg_qs_i reg2=0x12345678, read addr 0x08 -> reg_re_o=4'b0100 one cycle; rdata_o=0x12345678 with rvalid_o.
REQ-037 Read addr 0x10 (NumRegs=4), then write addr 0x05, then write be=0x3 -> no strobes, each response err_o=1, rdata_o=0; err_cnt_o=3 if macro defined.
REQ-038 rready_i held 0 for 5 cycles -> rvalid_o, rdata_o stable, gnt_o=0, req_i ignored; accepted the cycle after handshake.
REQ-039 Assert rst_ni low while in RESP -> rvalid_o=0 immediately, gnt_o=1 after release, no strobes.
REQ-040 256 erroneous requests with macro defined -> err_cnt_o saturates at 255.
